// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives per-phase datapath strobes, guards MEM with a timeout and counts retirements.
module multicycle_control #(
  parameter int OPWIDTH     = 2,
  parameter int MCODEBITS   = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 take_branch,
  input  logic                 mem_ack,
  input  logic                 last_instr,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 ALUSrc,
  output logic                 MoveCtrl,
  output logic                 MemtoReg,
  output logic                 Branch,
  output logic                 mem_rd,
  output logic                 mem_we,
  output logic                 RegWrite,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     retired
);

  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  localparam logic [MCODEBITS-1:0] OP_ADD  = MCODEBITS'(0);
  localparam logic [MCODEBITS-1:0] OP_ROR  = MCODEBITS'(1);
  localparam logic [MCODEBITS-1:0] OP_NAND = MCODEBITS'(2);
  localparam logic [MCODEBITS-1:0] OP_LD   = MCODEBITS'(3);
  localparam logic [MCODEBITS-1:0] OP_ST   = MCODEBITS'(4);
  localparam logic [MCODEBITS-1:0] OP_MOV  = MCODEBITS'(5);
  localparam logic [MCODEBITS-1:0] OP_BNE  = MCODEBITS'(6);
  localparam logic [MCODEBITS-1:0] OP_SET  = MCODEBITS'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [MCODEBITS-1:0]   op_q, op_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic                   err_q, err_d;
  logic                   retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      tmo_q     <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmo_d     = tmo_q;
    retired_d = retired_q;
    err_d     = err_q;
    retire    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ALUOp     = '0;
    ALUSrc    = 1'b0;
    MoveCtrl  = 1'b0;
    MemtoReg  = 1'b0;
    Branch    = 1'b0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    RegWrite  = 1'b0;
    done      = 1'b0;

    // Datapath mux selects stay stable from EXEC through WB of the latched opcode
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (op_q)
        OP_ADD:  ALUOp = OPWIDTH'(2'b00);
        OP_ROR:  ALUOp = OPWIDTH'(2'b01);
        OP_NAND: ALUOp = OPWIDTH'(2'b10);
        default: ALUOp = OPWIDTH'(2'b11);
      endcase
      ALUSrc   = (op_q == OP_SET);
      MoveCtrl = (op_q == OP_MOV);
      MemtoReg = (op_q == OP_LD);
      Branch   = (op_q == OP_BNE);
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        done = (state_q == S_HALT);
        if (start) begin
          state_d   = S_FETCH;
          err_d     = 1'b0;
          retired_d = '0;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_LD || op_q == OP_ST) begin
          tmo_d   = '0;
          state_d = S_MEM;
        end else if (op_q == OP_BNE) begin
          // Branch retires in EXEC, so the PC strobe follows the compare result directly
          pc_load = take_branch;
          pc_inc  = !take_branch;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_rd = (op_q == OP_LD);
        mem_we = (op_q == OP_ST);
        if (mem_ack) begin
          if (op_q == OP_LD) begin
            state_d = S_WB;
          end else begin
            pc_inc = 1'b1;
            retire = 1'b1;
          end
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_inc   = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      retired_d = sat_inc(retired_q);
      state_d   = last_instr ? S_HALT : S_FETCH;
    end
  end

  assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                   (state_q == S_MEM)   || (state_q == S_WB);
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model driving
// randomized programs, plus a narrow-counter instance for saturation.
module tb_multicycle_control;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset_n, start, take_branch, mem_ack, last_instr;
  logic [2:0] instr;

  logic        ir_load, pc_inc, pc_load, ALUSrc, MoveCtrl, MemtoReg, Branch;
  logic        mem_rd, mem_we, RegWrite, busy, done, err;
  logic [1:0]  ALUOp;
  logic [15:0] retired;

  logic        ir_load_b, pc_inc_b, pc_load_b, ALUSrc_b, MoveCtrl_b, MemtoReg_b, Branch_b;
  logic        mem_rd_b, mem_we_b, RegWrite_b, busy_b, done_b, err_b;
  logic [1:0]  ALUOp_b;
  logic [1:0]  retired_b;

  multicycle_control #(.OPWIDTH(2), .MCODEBITS(3), .MEM_TIMEOUT(TMO), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .take_branch(take_branch),
    .mem_ack(mem_ack), .last_instr(last_instr), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MoveCtrl(MoveCtrl),
    .MemtoReg(MemtoReg), .Branch(Branch), .mem_rd(mem_rd), .mem_we(mem_we),
    .RegWrite(RegWrite), .busy(busy), .done(done), .err(err), .retired(retired)
  );

  multicycle_control #(.OPWIDTH(2), .MCODEBITS(3), .MEM_TIMEOUT(TMO), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .take_branch(take_branch),
    .mem_ack(mem_ack), .last_instr(last_instr), .ir_load(ir_load_b), .pc_inc(pc_inc_b),
    .pc_load(pc_load_b), .ALUOp(ALUOp_b), .ALUSrc(ALUSrc_b), .MoveCtrl(MoveCtrl_b),
    .MemtoReg(MemtoReg_b), .Branch(Branch_b), .mem_rd(mem_rd_b), .mem_we(mem_we_b),
    .RegWrite(RegWrite_b), .busy(busy_b), .done(done_b), .err(err_b), .retired(retired_b)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {ir_load, pc_inc, pc_load, ALUOp, ALUSrc, MoveCtrl, MemtoReg, Branch,
                mem_rd, mem_we, RegWrite, busy, done, err};

  int          n_vec = 0;
  int          n_bad = 0;
  logic [14:0] exp_v;
  int          ret_m, ret2_m;
  bit          halted_m, err_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [14:0] ev(input bit ir, input bit pci, input bit pcl,
                                     input logic [5:0] f, input bit rd, input bit we,
                                     input bit rw, input bit bsy, input bit dn, input bit er);
    return {ir, pci, pcl, f, rd, we, rw, bsy, dn, er};
  endfunction

  // {ALUOp, ALUSrc, MoveCtrl, MemtoReg, Branch} for an opcode
  function automatic logic [5:0] fld(input logic [2:0] op);
    logic [1:0] aop;
    aop = (op < 3'd3) ? op[1:0] : 2'b11;
    return {aop, op == 3'd7, op == 3'd5, op == 3'd3, op == 3'd6};
  endfunction

  task automatic noise();
    start       = 1'($urandom);
    instr       = 3'($urandom);
    mem_ack     = 1'($urandom);
    take_branch = 1'($urandom);
    last_instr  = 1'($urandom);
  endtask

  task automatic step(input string tag);
    #1;
    check_eq(tag, {17'd0, obs}, {17'd0, exp_v});
    check_eq({tag, "_retired"}, {16'd0, retired}, ret_m);
    check_eq({tag, "_retired_sat"}, {30'd0, retired_b}, ret2_m);
    @(negedge clk);
  endtask

  task automatic retire_m(input bit last);
    if (ret_m < 65535) ret_m++;
    if (ret2_m < 3) ret2_m++;
    if (last) halted_m = 1'b1;
  endtask

  task automatic start_prog();
    noise();
    start = 1'b1;
    exp_v = ev(0, 0, 0, 6'd0, 0, 0, 0, 0, halted_m, err_m);
    step("start");
    start    = 1'b0;
    ret_m    = 0;
    ret2_m   = 0;
    err_m    = 1'b0;
    halted_m = 1'b0;
  endtask

  task automatic halt_check();
    noise();
    start = 1'b0;
    exp_v = ev(0, 0, 0, 6'd0, 0, 0, 0, 0, 1, err_m);
    step("halt");
  endtask

  // n = MEM cycle on which mem_ack arrives (0 = never)
  task automatic run_instr(input logic [2:0] op, input int n, input bit tb, input bit last);
    logic [5:0] f;
    bit         acked;
    f = fld(op);
    noise();
    exp_v = ev(1, 0, 0, 6'd0, 0, 0, 0, 1, 0, 0);
    step("fetch");
    noise();
    instr = op;
    exp_v = ev(0, 0, 0, 6'd0, 0, 0, 0, 1, 0, 0);
    step("decode");
    noise();
    if (op == 3'd6) begin
      take_branch = tb;
      last_instr  = last;
      exp_v = ev(0, !tb, tb, f, 0, 0, 0, 1, 0, 0);
      step("bne_exec");
      retire_m(last);
      return;
    end
    exp_v = ev(0, 0, 0, f, 0, 0, 0, 1, 0, 0);
    step("exec");
    if (op == 3'd3 || op == 3'd4) begin
      acked = 1'b0;
      for (int k = 1; k <= TMO; k++) begin
        noise();
        mem_ack = (k == n);
        if (op == 3'd4) last_instr = last;
        exp_v = ev(0, (op == 3'd4) && (k == n), 0, f, op == 3'd3, op == 3'd4, 0, 1, 0, 0);
        step("mem");
        if (k == n) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked) begin
        halted_m = 1'b1;
        err_m    = 1'b1;
        return;
      end
      if (op == 3'd4) begin
        retire_m(last);
        return;
      end
    end
    noise();
    last_instr = last;
    exp_v = ev(0, 1, 0, f, 0, 0, 1, 1, 0, 0);
    step("wb");
    retire_m(last);
  endtask

  task automatic run_random(input int cnt);
    logic [2:0] op;
    int         n;
    for (int i = 0; i < cnt; i++) begin
      op = 3'($urandom_range(0, 7));
      n  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
      run_instr(op, n, 1'($urandom), i == cnt - 1);
      if (halted_m) break;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; instr = '0; take_branch = 1'b0;
    mem_ack = 1'b0; last_instr = 1'b0;
    ret_m = 0; ret2_m = 0; halted_m = 1'b0; err_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_v = '0;
    step("reset");
    reset_n = 1'b1;
    step("idle");

    start_prog(); run_instr(3'd0, 0, 0, 1); halt_check();
    start_prog(); run_instr(3'd3, 3, 0, 1); halt_check();
    start_prog(); run_instr(3'd4, 0, 0, 1); halt_check();
    start_prog(); run_instr(3'd6, 0, 1, 0); run_instr(3'd6, 0, 0, 1); halt_check();

    // reset asserted during the second MEM cycle of a load
    start_prog();
    noise(); exp_v = ev(1, 0, 0, 6'd0, 0, 0, 0, 1, 0, 0); step("rfetch");
    noise(); instr = 3'd3; exp_v = ev(0, 0, 0, 6'd0, 0, 0, 0, 1, 0, 0); step("rdecode");
    noise(); exp_v = ev(0, 0, 0, fld(3'd3), 0, 0, 0, 1, 0, 0); step("rexec");
    noise(); mem_ack = 1'b0; exp_v = ev(0, 0, 0, fld(3'd3), 1, 0, 0, 1, 0, 0); step("rmem");
    noise(); reset_n = 1'b0;
    ret_m = 0; ret2_m = 0; err_m = 1'b0; halted_m = 1'b0; exp_v = '0;
    step("rst_mid");
    reset_n = 1'b1; start = 1'b0;
    step("idle_after");
    start_prog(); run_instr(3'd1, 0, 0, 1); halt_check();

    start_prog();
    for (int i = 0; i < 5; i++) begin
      logic [2:0] alu_ops [5];
      alu_ops = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd7};
      run_instr(alu_ops[$urandom_range(0, 4)], 0, 0, i == 4);
    end
    halt_check();

    repeat (8) begin
      start_prog();
      run_random(12);
      halt_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
